booth_r4_sequencer: RTL and testbench

Parametrised control sequencer for the radix-4 Booth multiplier. It replaces the fixed 8-bit counter/control pair with a WIDTH-generic FSM and an integrated iteration counter. It adds a single-cycle skip for no-op recodings (000/111), a synchronous abort, and busy/final handshake outputs. It drives the existing A/Q/M datapath through the c0..c7 strobe vector.

---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_iter_counter.sv | 26 ++
 rtl/booth_r4_sequencer.sv | 86 ++++++++
 tb/tb_booth_r4_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and recoding helpers for the radix-4 Booth control sequencer.
package booth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } booth_state_e;

  localparam int C_LOAD   = 0;
  localparam int C_ADD_M  = 1;
  localparam int C_ADD_2M = 2;
  localparam int C_SUB_M  = 3;
  localparam int C_SUB_2M = 4;
  localparam int C_COUNT  = 5;
  localparam int C_SHIFT  = 6;
  localparam int C_STORE  = 7;

  // Bit 0..3 of the result line up with strobes c[1..4]; zero means no-op.
  function automatic logic [3:0] booth_decode(input logic [2:0] q_lsb);
    logic [3:0] sel;
    case (q_lsb)
      3'b001, 3'b010: sel = 4'b0001;
      3'b011:         sel = 4'b0010;
      3'b101, 3'b110: sel = 4'b0100;
      3'b100:         sel = 4'b1000;
      default:        sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter with synchronous clear/increment and terminal flag.
// Latency: count updates on the edge after clr/inc; is_last is combinational.
// Backpressure: none.
module booth_iter_counter #(
  parameter int CNT_W = 2,
  parameter int LAST  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             is_last
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == CNT_W'(LAST));

endmodule

// File: rtl/booth_r4_sequencer.sv
// Radix-4 Booth control FSM driving the A/Q/M datapath through strobes c[7:0].
// Latency: start to final pulse is 3+WIDTH cycles, 3+WIDTH/2 when every recoding skips.
// Backpressure: none; start is ignored while busy, abort returns to IDLE.
module booth_r4_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SKIP_NOP = 1,
  localparam int N_IT    = WIDTH / 2,
  localparam int CNT_W   = (N_IT > 1) ? $clog2(N_IT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       q_lsb,
  output logic [7:0]       c,
  output logic             busy,
  output logic             final_pulse,  // "final" is a reserved word
  output logic [CNT_W-1:0] iter
);

  booth_state_e state, nxt;
  logic [7:0]   c_moore;
  logic         busy_r, final_r;
  logic [3:0]   sel;
  logic         skip, is_last;

  assign sel  = booth_decode(q_lsb);
  assign skip = (SKIP_NOP != 0) && (sel == 4'b0000);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_LOAD;
      ST_LOAD:  nxt = ST_ADD;
      ST_ADD:   if (!skip) nxt = ST_SHIFT;
                else       nxt = is_last ? ST_STORE : ST_ADD;
      ST_SHIFT: nxt = is_last ? ST_STORE : ST_ADD;
      ST_STORE: nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) nxt = ST_IDLE;
  end

  // Moore strobes are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      c_moore <= '0;
      busy_r  <= 1'b0;
      final_r <= 1'b0;
    end else begin
      state   <= nxt;
      c_moore <= {nxt == ST_STORE, {2{nxt == ST_SHIFT}}, 4'b0000, nxt == ST_LOAD};
      busy_r  <= nxt inside {ST_LOAD, ST_ADD, ST_SHIFT, ST_STORE};
      final_r <= (nxt == ST_DONE);
    end
  end

  always_comb begin
    c = c_moore;
    if (state == ST_ADD) begin
      c[C_SUB_2M:C_ADD_M] = sel;
      c[C_COUNT]          = skip;
      c[C_SHIFT]          = skip;
    end
  end

  assign busy        = busy_r;
  assign final_pulse = final_r;

  booth_iter_counter #(
    .CNT_W(CNT_W),
    .LAST (N_IT - 1)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (c[C_LOAD]),
    .inc    (c[C_COUNT]),
    .count  (iter),
    .is_last(is_last)
  );

endmodule

// File: tb/tb_booth_r4_sequencer.sv
// Randomized bench: three sequencer configurations, a behavioural A/Q/M datapath and Booth digit model.
module tb_booth_r4_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start, abort;
  logic [2:0] q_drv;

  logic [7:0] c0_w, c1_w, c2_w;
  logic       busy0, busy1, busy2, fin0, fin1, fin2;
  logic [1:0] it0, it1;
  logic [2:0] it2;

  booth_r4_sequencer #(.WIDTH(8), .SKIP_NOP(0)) u_w8_noskip (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .q_lsb(q_drv),
    .c(c0_w), .busy(busy0), .final_pulse(fin0), .iter(it0));

  booth_r4_sequencer #(.WIDTH(8), .SKIP_NOP(1)) u_w8_skip (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .q_lsb(q_drv),
    .c(c1_w), .busy(busy1), .final_pulse(fin1), .iter(it1));

  booth_r4_sequencer #(.WIDTH(16), .SKIP_NOP(1)) u_w16_skip (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]), .q_lsb(q_drv),
    .c(c2_w), .busy(busy2), .final_pulse(fin2), .iter(it2));

  int          sel_k = 0;
  logic [7:0]  c_s;
  logic        busy_s, fin_s;
  logic [63:0] iter_s;

  always_comb begin
    c_s = c0_w; busy_s = busy0; fin_s = fin0; iter_s = 64'(it0);
    if (sel_k == 1) begin c_s = c1_w; busy_s = busy1; fin_s = fin1; iter_s = 64'(it1); end
    if (sel_k == 2) begin c_s = c2_w; busy_s = busy2; fin_s = fin2; iter_s = 64'(it2); end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe legality on every configuration, every cycle.
  int viol = 0;
  always @(negedge clk) begin
    if (!$onehot0(c0_w[4:1]) || c0_w[5] !== c0_w[6]) viol++;
    if (!$onehot0(c1_w[4:1]) || c1_w[5] !== c1_w[6]) viol++;
    if (!$onehot0(c2_w[4:1]) || c2_w[5] !== c2_w[6]) viol++;
  end

  typedef struct {
    logic [7:0] c;
    logic       busy;
    logic       fin;
    int         iter;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done_cyc;

  longint dA, dQ, dM;
  bit     dqm1;

  function automatic longint sext(input logic [15:0] v, input int w);
    longint x;
    x = longint'(v) & ((64'sd1 <<< w) - 1);
    if (((x >> (w - 1)) & 1) != 0) x = x - (64'sd1 <<< w);
    return x;
  endfunction

  // Expected strobe trace from the Booth digits d_i = -2*b(2i+1) + b(2i) + b(2i-1).
  task automatic build_expect(input int w, input bit skip, input logic [15:0] mult,
                              input bit hold, input logic [2:0] hv);
    int b2, b1, b0, d;
    logic [7:0] stb;
    exp_q.delete();
    exp_q.push_back('{8'h01, 1'b1, 1'b0, -1});
    for (int i = 0; i < w / 2; i++) begin
      if (hold) begin
        b2 = int'(hv[2]); b1 = int'(hv[1]); b0 = int'(hv[0]);
      end else begin
        b2 = int'(mult[2*i+1]); b1 = int'(mult[2*i]);
        b0 = (i == 0) ? 0 : int'(mult[2*i-1]);
      end
      d = -2 * b2 + b1 + b0;
      case (d)
        1:       stb = 8'h02;
        2:       stb = 8'h04;
        -1:      stb = 8'h08;
        -2:      stb = 8'h10;
        default: stb = 8'h00;
      endcase
      if (d == 0 && skip) begin
        exp_q.push_back('{8'h60, 1'b1, 1'b0, i});
      end else begin
        exp_q.push_back('{stb, 1'b1, 1'b0, i});
        exp_q.push_back('{8'h60, 1'b1, 1'b0, i});
      end
    end
    exp_q.push_back('{8'h80, 1'b1, 1'b0, -1});
    exp_q.push_back('{8'h00, 1'b0, 1'b1, -1});
    exp_done_cyc = exp_q.size();
    exp_q.push_back('{8'h00, 1'b0, 1'b0, -1});
    exp_q.push_back('{8'h00, 1'b0, 1'b0, -1});
  endtask

  task automatic datapath_step(input logic [7:0] cs, input int w, input logic [15:0] mult,
                               input logic [15:0] mcand);
    if (cs[0]) begin
      dA = 0; dQ = longint'(mult) & ((64'sd1 <<< w) - 1); dqm1 = 1'b0; dM = sext(mcand, w);
    end
    if (cs[1]) dA = dA + dM;
    if (cs[2]) dA = dA + 2 * dM;
    if (cs[3]) dA = dA - dM;
    if (cs[4]) dA = dA - 2 * dM;
    if (cs[6]) begin
      dqm1 = ((dQ >> 1) & 1) != 0;
      dQ   = (dQ >> 2) | ((dA & 3) << (w - 2));
      dA   = dA >>> 2;
    end
  endtask

  task automatic run_op(input int k, input int w, input bit skip, input logic [15:0] mult,
                        input logic [15:0] mcand, input bit hold, input logic [2:0] hv,
                        input int abort_cyc, input bit noise, input bit ab_idle);
    int fin_cyc;
    logic [7:0] cs;
    longint prod, ref_prod, mask2;
    build_expect(w, skip, mult, hold, hv);
    if (abort_cyc > 0) begin
      while (exp_q.size() > abort_cyc) void'(exp_q.pop_back());
      repeat (3) exp_q.push_back('{8'h00, 1'b0, 1'b0, -1});
    end
    sel_k = k;
    @(posedge clk); #1;
    start[k] = 1'b1;
    abort[k] = ab_idle;
    q_drv    = hold ? hv : 3'b000;
    @(posedge clk); #1;
    start[k] = 1'b0;
    fin_cyc  = 0;
    for (int cyc = 1; cyc <= exp_q.size(); cyc++) begin
      abort[k] = (cyc == abort_cyc);
      start[k] = noise && cyc >= 2 && (exp_q[cyc-1].busy || exp_q[cyc-1].fin);
      @(negedge clk);
      check_eq($sformatf("k%0d cyc%0d c", k, cyc), 64'(c_s), 64'(exp_q[cyc-1].c));
      check_eq($sformatf("k%0d cyc%0d busy", k, cyc), 64'(busy_s), 64'(exp_q[cyc-1].busy));
      check_eq($sformatf("k%0d cyc%0d final", k, cyc), 64'(fin_s), 64'(exp_q[cyc-1].fin));
      if (exp_q[cyc-1].iter >= 0)
        check_eq($sformatf("k%0d cyc%0d iter", k, cyc), iter_s, 64'(exp_q[cyc-1].iter));
      if (fin_s === 1'b1 && fin_cyc == 0) fin_cyc = cyc;
      cs = c_s;
      @(posedge clk); #1;
      datapath_step(cs, w, mult, mcand);
      if (!hold) q_drv = {dQ[1:0], dqm1};
    end
    start[k] = 1'b0;
    abort[k] = 1'b0;
    if (abort_cyc > 0) begin
      check_eq($sformatf("k%0d aborted final", k), 64'(fin_cyc), 64'd0);
    end else begin
      check_eq($sformatf("k%0d latency", k), 64'(fin_cyc), 64'(exp_done_cyc));
      if (!hold) begin
        mask2    = (64'sd1 <<< (2 * w)) - 1;
        prod     = (((dA & ((64'sd1 <<< w) - 1)) << w) | dQ) & mask2;
        ref_prod = (sext(mult, w) * sext(mcand, w)) & mask2;
        check_eq($sformatf("k%0d product %0h*%0h", k, mult, mcand), prod, ref_prod);
      end
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; start = '0; abort = '0; q_drv = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst c", {40'd0, c0_w, c1_w, c2_w}, 64'd0);
    check_eq("rst busy/final", {58'd0, busy0, busy1, busy2, fin0, fin1, fin2}, 64'd0);
    check_eq("rst iter", {57'd0, it0, it1, it2}, 64'd0);

    // Held recodings on both 8-bit configurations cover every q_lsb pattern.
    for (int hv = 0; hv < 8; hv++) begin
      run_op(0, 8, 1'b0, 16'h0, 16'h0, 1'b1, 3'(hv), 0, 1'b0, 1'b0);
      run_op(1, 8, 1'b1, 16'h0, 16'h0, 1'b1, 3'(hv), 0, 1'b0, 1'b0);
    end

    run_op(2, 16, 1'b1, 16'hB3A5, 16'h7FFF, 1'b0, 3'b0, 0, 1'b0, 1'b0);

    // Abort in the second SHIFT, then a clean run on the same instance.
    run_op(0, 8, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 3'b0, 5, 1'b0, 1'b0);
    run_op(0, 8, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 3'b0, 0, 1'b0, 1'b0);

    // Start held through busy and DONE, and start together with abort in IDLE.
    run_op(1, 8, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 3'b0, 0, 1'b1, 1'b1);
    run_op(2, 16, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 3'b0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 2));
      run_op(k, (k == 2) ? 16 : 8, k != 0, 16'($urandom), 16'($urandom), 1'b0, 3'b0, 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset together with abort in the second ADD.
    sel_k = 0;
    @(posedge clk); #1;
    start[0] = 1'b1; q_drv = 3'b011;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("pre-reset c", 64'(c_s), 64'h04);
    check_eq("pre-reset iter", iter_s, 64'd1);
    reset = 1'b1; abort[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; abort[0] = 1'b0;
    @(negedge clk);
    check_eq("post-reset c", 64'(c_s), 64'd0);
    check_eq("post-reset busy/final", {62'd0, busy_s, fin_s}, 64'd0);
    check_eq("post-reset iter", iter_s, 64'd0);
    @(negedge clk);
    check_eq("post-reset idle", {55'd0, busy_s, c_s}, 64'd0);

    check_eq("strobe legality violations", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
